// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding
// and the sizing rule for the single shared press timer.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_WAIT_SECOND    = 3'd2,
        ST_SECOND_PRESSED = 3'd3,
        ST_LONG_HELD      = 3'd4
    } state_t;

    // Width of the press timer: enough bits for the largest interval plus one,
    // so the terminal value of every interval fits below the saturation point.
    function automatic int timer_width(input int long_c, input int gap_c, input int rep_c);
        int max_c;
        max_c = long_c;
        if (gap_c > max_c) begin
            max_c = gap_c;
        end else begin
            max_c = max_c;
        end
        if (rep_c > max_c) begin
            max_c = rep_c;
        end else begin
            max_c = max_c;
        end
        return $clog2(max_c) + 32'sd1;
    endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating up-counter shared by all FSM states. clear has priority over
// enable; once all ones the count holds until cleared.
module press_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count up each enabled cycle, restart on clear, stick at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable && (count_r != COUNT_MAX)) begin
            count_r <= count_r + COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/button_press_classifier.sv
// Button press classifier: turns debounced press/release pulses into
// short / double / long press pulses.
// Optional feature macro: BUTTON_PRESS_CLASSIFIER_REPEAT_EN adds the
// repeat_press output, pulsing periodically while a long press is held.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic double_press,
    output logic long_press,
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    output logic busy,
    output logic repeat_press
`else
    output logic busy
`endif
);

    localparam int TW = timer_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);

    // Timer values seen in the last cycle of each interval.
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
`endif

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   timer_s;
    logic            clear_s;
    logic            down_s;
    logic            up_s;
    logic            short_nxt_s;
    logic            double_nxt_s;
    logic            long_nxt_s;
    logic            short_r;
    logic            double_r;
    logic            long_r;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    logic            rep_fire_s;
    logic            repeat_r;
`endif

    // Simultaneous press and release is contradictory, so both are dropped.
    assign down_s = pb_down & ~pb_up;
    assign up_s   = pb_up & ~pb_down;

    // Next-state and pulse-request decode. An event arriving in the final
    // cycle of an interval wins over the timeout, including a release on the
    // very cycle a long press would otherwise qualify.
    always_comb begin
        state_nxt_s  = state_r;
        short_nxt_s  = 1'b0;
        double_nxt_s = 1'b0;
        long_nxt_s   = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
        rep_fire_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (down_s) begin
                    state_nxt_s = ST_PRESSED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (up_s) begin
                    state_nxt_s = ST_WAIT_SECOND;
                end else if (timer_s == LONG_LAST) begin
                    state_nxt_s = ST_LONG_HELD;
                    long_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_WAIT_SECOND: begin
                if (down_s) begin
                    state_nxt_s = ST_SECOND_PRESSED;
                end else if (timer_s == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                    short_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_SECOND;
                end
            end
            ST_SECOND_PRESSED: begin
                if (up_s) begin
                    state_nxt_s  = ST_IDLE;
                    double_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SECOND_PRESSED;
                end
            end
            ST_LONG_HELD: begin
                if (up_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LONG_HELD;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
                    if (timer_s == REP_LAST) begin
                        rep_fire_s = 1'b1;
                    end else begin
                        rep_fire_s = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The timer restarts on every state change; in repeat mode it also
    // restarts on each repeat pulse so the period stays exact.
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    assign clear_s = (state_nxt_s != state_r) | rep_fire_s;
`else
    assign clear_s = (state_nxt_s != state_r);
`endif

    press_timer #(
        .WIDTH (TW)
    ) u_press_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear_s),
        .enable (1'b1),
        .count  (timer_s)
    );

    // State register plus registered one-cycle classification pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
            repeat_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            short_r  <= short_nxt_s;
            double_r <= double_nxt_s;
            long_r   <= long_nxt_s;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
            repeat_r <= rep_fire_s;
`endif
        end
    end

    assign short_press  = short_r;
    assign double_press = double_r;
    assign long_press   = long_r;
    assign busy         = (state_r != ST_IDLE);
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    assign repeat_press = repeat_r;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: directed vector table
// followed by randomized stimulus against a timestamp-based reference model.
module tb_button_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 6;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_down = 1'b0;
    logic pb_up = 1'b0;
    logic short_press;
    logic double_press;
    logic long_press;
    logic busy;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    logic repeat_press;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_press_classifier #(
        .LONG_CYCLES   (LONG),
        .GAP_CYCLES    (GAP),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_down      (pb_down),
        .pb_up        (pb_up),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
        .busy         (busy),
        .repeat_press (repeat_press)
`else
        .busy         (busy)
`endif
    );

    task automatic check(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Directed vectors: event cycles (-1 = none) and expected pulse cycles.
    typedef struct {
        string name;
        int n;
        int d0, d1, u0, u1;
        int rlo, rhi;
        int s, dbl, lng;
        int r0, r1;
        int b1lo, b1hi, b2lo, b2hi;
    } vec_t;

    vec_t vecs [8];

    function automatic logic in_win(input int c, input int lo, input int hi);
        return (lo >= 0) && (c >= lo) && (c <= hi);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pb_down = 1'b0;
        pb_up = 1'b0;
        #1;
        check("reset short", short_press, 1'b0);
        check("reset double", double_press, 1'b0);
        check("reset long", long_press, 1'b0);
        check("reset busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: remembers when the current sequence started, when
    // the first release happened and whether a second press or long hold
    // is in progress; outputs are predicted for the next cycle.
    int  gc;
    bit  m_seq, m_second, m_long;
    int  t_down, t_up, t_long_entry;
    logic e_short, e_double, e_long, e_rep, e_busy;

    task automatic model_reset();
        m_seq = 1'b0; m_second = 1'b0; m_long = 1'b0;
        t_down = -1; t_up = -1; t_long_entry = -1;
        e_short = 1'b0; e_double = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic d_in, input logic u_in);
        logic d, u;
        d = d_in; u = u_in;
        e_short = 1'b0; e_double = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (!r) begin
            model_reset();
        end else begin
            if (d && u) begin
                d = 1'b0; u = 1'b0;
            end
            if (!m_seq) begin
                if (d) begin
                    m_seq = 1'b1; m_second = 1'b0; m_long = 1'b0;
                    t_down = gc; t_up = -1;
                end
            end else if (m_long) begin
                if (u) m_seq = 1'b0;
                else if (((gc + 1 - t_long_entry) % REP) == 0) e_rep = 1'b1;
            end else if (m_second) begin
                if (u) begin
                    m_seq = 1'b0; e_double = 1'b1;
                end
            end else if (t_up < 0) begin
                if (u) t_up = gc;
                else if (gc - t_down == LONG) begin
                    m_long = 1'b1; e_long = 1'b1; t_long_entry = gc + 1;
                end
            end else begin
                if (d) m_second = 1'b1;
                else if (gc - t_up == GAP) begin
                    m_seq = 1'b0; e_short = 1'b1;
                end
            end
            e_busy = m_seq;
        end
        gc++;
    endtask

    initial begin
        vecs[0] = '{"short",        14, 0, -1,  3, -1, -1, -1, 10, -1, -1, -1, -1, 1,  9, -1, -1};
        vecs[1] = '{"double",       12, 0,  5,  2,  7, -1, -1, -1,  8, -1, -1, -1, 1,  7, -1, -1};
        vecs[2] = '{"long",         24, 0, -1, 20, -1, -1, -1, -1, -1,  9, 13, 17, 1, 20, -1, -1};
        vecs[3] = '{"edge_double",  14, 0,  8,  2, 10, -1, -1, -1, 11, -1, -1, -1, 1, 10, -1, -1};
        vecs[4] = '{"reset_mid",    18, 0,  7,  2,  8,  4,  5, 15, -1, -1, -1, -1, 1,  3,  8, 14};
        vecs[5] = '{"both_same",     6, 0, -1,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        vecs[6] = '{"late_release", 17, 0, -1,  7, -1, -1, -1, 14, -1, -1, -1, -1, 1, 13, -1, -1};
        vecs[7] = '{"ignored_down", 14, 0,  2,  3, -1, -1, -1, 10, -1, -1, -1, -1, 1,  9, -1, -1};

        // Table-driven directed vectors.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int c = 0; c < vecs[v].n; c++) begin
                @(negedge clk);
                rst_n = in_win(c, vecs[v].rlo, vecs[v].rhi) ? 1'b0 : 1'b1;
                #1;
                check($sformatf("%s short c%0d", vecs[v].name, c), short_press, c == vecs[v].s);
                check($sformatf("%s double c%0d", vecs[v].name, c), double_press, c == vecs[v].dbl);
                check($sformatf("%s long c%0d", vecs[v].name, c), long_press, c == vecs[v].lng);
                check($sformatf("%s busy c%0d", vecs[v].name, c), busy,
                      in_win(c, vecs[v].b1lo, vecs[v].b1hi) || in_win(c, vecs[v].b2lo, vecs[v].b2hi));
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
                check($sformatf("%s repeat c%0d", vecs[v].name, c), repeat_press,
                      (c == vecs[v].r0) || (c == vecs[v].r1));
`endif
                pb_down = (c == vecs[v].d0) || (c == vecs[v].d1);
                pb_up   = (c == vecs[v].u0) || (c == vecs[v].u1);
            end
            pb_down = 1'b0;
            pb_up = 1'b0;
        end

        // Press in the very first clock after reset release is accepted.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pb_down = 1'b1;
        @(negedge clk);
        #1;
        check("down_after_reset busy", busy, 1'b1);
        pb_down = 1'b0;
        pb_up = 1'b1;
        @(negedge clk);
        #1;
        pb_up = 1'b0;
        check("down_after_reset release busy", busy, 1'b1);

        // Randomized stimulus against the reference model.
        do_reset();
        gc = 0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic d, u;
            @(negedge clk);
            if (!rst_n) rst_n = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
            else rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            #1;
            if (!rst_n) model_reset();
            check($sformatf("rand short i%0d", i), short_press, e_short);
            check($sformatf("rand double i%0d", i), double_press, e_double);
            check($sformatf("rand long i%0d", i), long_press, e_long);
            check($sformatf("rand busy i%0d", i), busy, e_busy);
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
            check($sformatf("rand repeat i%0d", i), repeat_press, e_rep);
`endif
            d = ($urandom_range(0, 5) == 0);
            u = ($urandom_range(0, 5) == 0);
            pb_down = d;
            pb_up = u;
            model_step(rst_n, d, u);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
